// File: rtl/uart_rx_if.sv
// Receive-side bus of the UART receiver.
// Output handshake: there is no ready. rx_valid_o is a one-cycle pulse that
// marks the cycle rx_data_o takes a new word; rx_data_o then holds until the
// next valid frame. frame_err_o and parity_err_o are one-cycle pulses;
// parity_err_o only ever accompanies rx_valid_o, and frame_err_o never does.
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] rx_data_o;
    logic                  rx_valid_o;
    logic                  frame_err_o;
    logic                  parity_err_o;
    logic                  busy_o;
    logic [2:0]            dbg_state_o;  // receiver FSM state, for observation

    modport master (
        output rx_data_o,
        output rx_valid_o,
        output frame_err_o,
        output parity_err_o,
        output busy_o,
        output dbg_state_o
    );

    modport slave (
        input rx_data_o,
        input rx_valid_o,
        input frame_err_o,
        input parity_err_o,
        input busy_o,
        input dbg_state_o
    );
endinterface

// File: rtl/uart_rx.sv
// UART serial receiver. Synchronises rx_i, qualifies the start bit at its
// centre, then samples data/parity/stop bits at mid-bit using the
// OVERSAMPLE-per-bit enable from the baud generator. Data is LSB-first.
module uart_rx #(
    parameter int DATA_WIDTH  = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      baud_en_i,
    input  logic      rx_i,
    uart_rx_if.master bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_WIDTH);

    localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic          PAR_ON   = (PARITY_EN != 0);
    localparam logic          PAR_ODD  = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                  rx_s;
    logic                  rx_q;
    logic [TW-1:0]         tick_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  parity_bad;

    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  frame_err;
    logic                  parity_err;
    logic                  busy;

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Input synchroniser plus one delayed copy for falling-edge detection;
    // all flops reset to the idle-high line level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '1;
            rx_q   <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
            rx_q   <= rx_s;
        end
    end

    // Receiver FSM: every transition also updates the registered busy flag,
    // and the result pulses default low each cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= S_IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            parity_bad <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Only a high-to-low transition starts a frame, so a
                    // line stuck low never retriggers.
                    if (rx_q && !rx_s) begin
                        state    <= S_START;
                        tick_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                S_START: begin
                    if (baud_en_i) begin
                        if (tick_cnt == HALF_M1) begin
                            tick_cnt <= '0;
                            if (rx_s) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end else begin
                                bit_cnt <= '0;
                                state   <= S_DATA;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                S_DATA: begin
                    if (baud_en_i) begin
                        if (tick_cnt == FULL_M1) begin
                            tick_cnt <= '0;
                            shreg    <= {rx_s, shreg[DATA_WIDTH-1:1]};
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt <= '0;
                                state   <= PAR_ON ? S_PARITY : S_STOP;
                            end else begin
                                bit_cnt <= bit_cnt + BW'(1);
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (baud_en_i) begin
                        if (tick_cnt == FULL_M1) begin
                            tick_cnt   <= '0;
                            parity_bad <= (^shreg) ^ rx_s ^ PAR_ODD;
                            state      <= S_STOP;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                S_STOP: begin
                    if (baud_en_i) begin
                        if (tick_cnt == FULL_M1) begin
                            // Back to IDLE at stop-bit centre so a following
                            // start edge is caught without dead time.
                            tick_cnt <= '0;
                            state    <= S_IDLE;
                            busy     <= 1'b0;
                            if (rx_s) begin
                                rx_data    <= shreg;
                                rx_valid   <= 1'b1;
                                parity_err <= parity_bad & PAR_ON;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    tick_cnt <= '0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_data_o    = rx_data;
    assign bus.rx_valid_o   = rx_valid;
    assign bus.frame_err_o  = frame_err;
    assign bus.parity_err_o = parity_err;
    assign bus.busy_o       = busy;
    assign bus.dbg_state_o  = state;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an 8N1 receiver (line a) and an 8E1 receiver (line b)
// share clock, reset and a baud enable every 4 cycles (64 cycles per bit).
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int W = 10;  // {is_frame_err, parity_err, data[7:0]}

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic baud_en = 1'b0;
  logic [1:0] bcnt = 2'd0;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;

  int n_checks = 0;
  int n_fail = 0;

  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];
  logic [7:0] last_data[2];

  uart_rx_if #(.DATA_WIDTH(8)) bus_a ();
  uart_rx_if #(.DATA_WIDTH(8)) bus_b ();

  uart_rx #(.DATA_WIDTH(8), .OVERSAMPLE(16), .SYNC_STAGES(2),
            .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .baud_en_i(baud_en), .rx_i(rx_a), .bus(bus_a)
  );

  uart_rx #(.DATA_WIDTH(8), .OVERSAMPLE(16), .SYNC_STAGES(2),
            .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .baud_en_i(baud_en), .rx_i(rx_b), .bus(bus_b)
  );

  // clock / baud enable
  always #5 clk = ~clk;

  always @(posedge clk) begin
    bcnt    <= bcnt + 2'd1;
    baud_en <= (bcnt == 2'd2);
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d fails=%0d", n_checks, n_fail);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_line(input bit sel, input logic v);
    if (sel) rx_b = v;
    else rx_a = v;
  endtask

  // Drives start, 8 data bits LSB-first, parity (line b only) and the stop
  // bit; leaves the line at the stop level. Queues the expected outcome.
  task automatic send_frame(input bit sel, input logic [7:0] d, input logic pbit,
                            input logic stop, input int per);
    logic [W-1:0] e;
    logic perr;
    perr = sel ? ((^d) ^ pbit) : 1'b0;  // even parity on line b
    e = stop ? {1'b0, perr, d} : {1'b1, 1'b0, d};
    if (sel) exp_b_q.push_back(e);
    else exp_a_q.push_back(e);
    drive_line(sel, 1'b0);
    hold(per);
    for (int i = 0; i < 8; i++) begin
      drive_line(sel, d[i]);
      hold(per);
    end
    if (sel) begin
      drive_line(sel, pbit);
      hold(per);
    end
    drive_line(sel, stop);
    hold(per);
  endtask

  // scoreboard: every pulse on a receiver must match the head of its queue
  task automatic mon_step(input bit sel, input logic v, input logic f,
                          input logic p, input logic [7:0] d);
    logic [W-1:0] e;
    int qs;
    if (p && !v) check("perr_without_valid", v, 1);
    if (v || f) begin
      check("valid_ferr_exclusive", v & f, 0);
      qs = sel ? exp_b_q.size() : exp_a_q.size();
      if (qs == 0) begin
        check("unexpected_pulse", {v, f}, 0);
      end else begin
        e = sel ? exp_b_q.pop_front() : exp_a_q.pop_front();
        check("pulse_kind", {v, f}, e[9] ? 2'b01 : 2'b10);
        if (!e[9]) begin
          check("rx_data", d, e[7:0]);
          check("parity_err", p, e[8]);
          last_data[sel] = e[7:0];
        end else begin
          check("data_held_on_ferr", d, last_data[sel]);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon_step(1'b0, bus_a.rx_valid_o, bus_a.frame_err_o, bus_a.parity_err_o, bus_a.rx_data_o);
      mon_step(1'b1, bus_b.rx_valid_o, bus_b.frame_err_o, bus_b.parity_err_o, bus_b.rx_data_o);
    end
  end

  // main sequence
  initial begin
    logic [7:0] d;
    logic stop;
    int per;
    last_data[0] = 8'h00;
    last_data[1] = 8'h00;

    hold(5);
    check("rst_a_data", bus_a.rx_data_o, 0);
    check("rst_a_valid", bus_a.rx_valid_o, 0);
    check("rst_a_ferr", bus_a.frame_err_o, 0);
    check("rst_a_perr", bus_a.parity_err_o, 0);
    check("rst_a_busy", bus_a.busy_o, 0);
    check("rst_b_data", bus_b.rx_data_o, 0);
    check("rst_b_busy", bus_b.busy_o, 0);
    rst_n = 1'b1;
    hold(20);

    // ideal 8N1 byte
    send_frame(1'b0, 8'hA5, 1'b0, 1'b1, 64);
    hold(64);
    check("a5_busy_idle", bus_a.busy_o, 0);

    // start-bit glitch: low for 5 ticks, then high
    drive_line(1'b0, 1'b0);
    hold(12);
    check("glitch_busy_high", bus_a.busy_o, 1);
    hold(8);
    drive_line(1'b0, 1'b1);
    hold(40);
    check("glitch_busy_low", bus_a.busy_o, 0);
    hold(64);

    // framing error followed by a held-low line (3 bit times low)
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 64);
    hold(64);
    check("break_no_retrigger", bus_a.busy_o, 0);
    hold(64);
    check("break_still_idle", bus_a.busy_o, 0);
    drive_line(1'b0, 1'b1);
    hold(64);
    send_frame(1'b0, 8'h3C, 1'b0, 1'b1, 64);
    hold(64);

    // parity: good then bad even parity for 0x07
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 64);
    hold(64);
    send_frame(1'b1, 8'h07, 1'b0, 1'b1, 64);
    hold(64);

    // back-to-back with skewed bit periods
    send_frame(1'b0, 8'h00, 1'b0, 1'b1, 66);
    send_frame(1'b0, 8'hFF, 1'b0, 1'b1, 62);
    hold(100);

    // reset during bit 4 of 0x55: aborted frame must leave no trace
    drive_line(1'b0, 1'b0);
    hold(64);
    for (int i = 0; i < 4; i++) begin
      drive_line(1'b0, (i % 2 == 0) ? 1'b1 : 1'b0);
      hold(64);
    end
    drive_line(1'b0, 1'b1);
    hold(30);
    check("pre_reset_busy", bus_a.busy_o, 1);
    rst_n = 1'b0;
    hold(4);
    check("midreset_busy", bus_a.busy_o, 0);
    check("midreset_data", bus_a.rx_data_o, 0);
    last_data[0] = 8'h00;
    last_data[1] = 8'h00;
    rst_n = 1'b1;
    hold(64);
    send_frame(1'b0, 8'h81, 1'b0, 1'b1, 64);
    hold(100);

    // randomized frames on both lines
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom_range(0, 255));
      per = $urandom_range(62, 66);
      stop = ($urandom_range(0, 5) != 0);
      send_frame(1'b0, d, 1'b0, stop, per);
      drive_line(1'b0, 1'b1);
      hold(stop ? $urandom_range(0, 40) : 70);
    end
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom_range(0, 255));
      per = $urandom_range(62, 66);
      stop = ($urandom_range(0, 5) != 0);
      send_frame(1'b1, d, 1'($urandom_range(0, 1)), stop, per);
      drive_line(1'b1, 1'b1);
      hold(stop ? $urandom_range(0, 40) : 70);
    end
    hold(200);

    // final report
    check("a_queue_drained", exp_a_q.size(), 0);
    check("b_queue_drained", exp_b_q.size(), 0);
    check("end_a_busy", bus_a.busy_o, 0);
    check("end_b_busy", bus_b.busy_o, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
